// File: rtl/tpu_multislot_if.sv
// Host byte bus and radio-side outputs of the multislot timing processing unit.
// The host drives the master side; the timing unit is the slave.
interface tpu_multislot_if #(
    parameter int N_CH = 4
);
    logic [7:0]      addr;
    logic [7:0]      data_in;
    logic            we;
    logic [7:0]      data_out;
    logic            TPUINT;
    logic [N_CH-1:0] G_CLK_EN;

    modport master (
        output addr, data_in, we,
        input  data_out, TPUINT, G_CLK_EN
    );

    modport slave (
        input  addr, data_in, we,
        output data_out, TPUINT, G_CLK_EN
    );
endinterface

// File: rtl/tpu_multislot.sv
// Timing processing unit: byte register file, prescaled frame timer and
// N_CH programmable slot-gate channels with wrap-around and one-shot windows.
module tpu_multislot #(
    parameter int N_CH    = 4,
    parameter int TIME_W  = 7,
    parameter int PRESC_W = 16
) (
    input  logic             SYS_CLK,
    input  logic             RST,
    tpu_multislot_if.slave   bus
);
    localparam logic [7:0] A_CTRL    = 8'h00;
    localparam logic [7:0] A_STATUS  = 8'h01;
    localparam logic [7:0] A_PRESC_L = 8'h02;
    localparam logic [7:0] A_PRESC_H = 8'h03;
    localparam logic [7:0] A_INT_T   = 8'h04;
    localparam logic [7:0] A_TIME    = 8'h05;
    localparam logic [7:0] A_CH_EN   = 8'h06;
    localparam logic [7:0] A_ONESHOT = 8'h07;
    localparam logic [7:0] A_ACTIVE  = 8'h08;
    localparam logic [7:0] A_CH_BASE = 8'h10;
    localparam logic [7:0] A_CH_END  = 8'(16 + 2 * N_CH);

    logic               r_run;
    logic               r_intmsk;
    logic               r_intflag;
    logic               r_frameflag;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pcnt;
    logic [TIME_W-1:0]  r_int_time;
    logic [TIME_W-1:0]  r_time;
    logic [N_CH-1:0]    r_ch_en;
    logic [N_CH-1:0]    r_oneshot;
    logic [N_CH-1:0]    r_gate;
    logic [TIME_W-1:0]  r_start [N_CH];
    logic [TIME_W-1:0]  r_len   [N_CH];
    logic [7:0]         r_dout;

    logic               w_wr_ctrl, w_wr_status, w_rsttpu, w_tick, w_ch_hit, w_ch_wr, w_ch_len;
    logic [2:0]         w_ch_idx;
    logic [TIME_W-1:0]  w_time_nxt;
    logic [15:0]        w_presc16;
    logic [N_CH-1:0]    w_win;
    logic [N_CH-1:0]    w_fall;
    logic [7:0]         w_rdata;

    assign w_wr_ctrl   = bus.we && (bus.addr == A_CTRL);
    assign w_wr_status = bus.we && (bus.addr == A_STATUS);
    assign w_rsttpu    = w_wr_ctrl && bus.data_in[0];
    assign w_tick      = r_run && (r_pcnt >= r_presc);
    assign w_time_nxt  = r_time + TIME_W'(1);
    assign w_presc16   = 16'(r_presc);
    assign w_ch_hit    = (bus.addr >= A_CH_BASE) && (bus.addr < A_CH_END);
    assign w_ch_wr     = bus.we && w_ch_hit;
    assign w_ch_idx    = bus.addr[3:1];
    assign w_ch_len    = bus.addr[0];

    // Window test per channel; the modular difference handles windows that wrap through 0
    always_comb begin
        w_win = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_win[c] = r_run & r_ch_en[c] & (TIME_W'(r_time - r_start[c]) < r_len[c]);
        end
        w_fall = r_gate & ~w_win & {N_CH{~w_rsttpu}};
    end

    // Register read mux
    always_comb begin
        w_rdata = 8'h00;
        case (bus.addr)
            A_CTRL:    w_rdata = {5'b00000, r_run, r_intmsk, 1'b0};
            A_STATUS:  w_rdata = {6'b000000, r_frameflag, r_intflag};
            A_PRESC_L: w_rdata = w_presc16[7:0];
            A_PRESC_H: w_rdata = w_presc16[15:8];
            A_INT_T:   w_rdata = 8'(r_int_time);
            A_TIME:    w_rdata = 8'(r_time);
            A_CH_EN:   w_rdata = 8'(r_ch_en);
            A_ONESHOT: w_rdata = 8'(r_oneshot);
            A_ACTIVE:  w_rdata = 8'(r_gate);
            default: begin
                w_rdata = 8'h00;
                for (int c = 0; c < N_CH; c++) begin
                    w_rdata = w_rdata | ((w_ch_hit && (w_ch_idx == 3'(c))) ?
                              (w_ch_len ? 8'(r_len[c]) : 8'(r_start[c])) : 8'h00);
                end
            end
        endcase
    end

    // Host-written configuration, control bits and read data
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_run      <= 1'b0;
            r_intmsk   <= 1'b0;
            r_presc    <= '0;
            r_int_time <= '0;
            r_oneshot  <= '0;
            r_dout     <= 8'h00;
            for (int c = 0; c < N_CH; c++) begin
                r_start[c] <= '0;
                r_len[c]   <= '0;
            end
        end else begin
            r_dout <= w_rdata;
            if (w_wr_ctrl) begin
                r_intmsk <= bus.data_in[1];
                r_run    <= bus.data_in[2];
            end
            if (bus.we && (bus.addr == A_PRESC_L)) r_presc <= PRESC_W'({w_presc16[15:8], bus.data_in});
            if (bus.we && (bus.addr == A_PRESC_H)) r_presc <= PRESC_W'({bus.data_in, w_presc16[7:0]});
            if (bus.we && (bus.addr == A_INT_T))   r_int_time <= bus.data_in[TIME_W-1:0];
            if (bus.we && (bus.addr == A_ONESHOT)) r_oneshot  <= bus.data_in[N_CH-1:0];
            for (int c = 0; c < N_CH; c++) begin
                if (w_ch_wr && (w_ch_idx == 3'(c))) begin
                    if (w_ch_len) r_len[c]   <= bus.data_in[TIME_W-1:0];
                    else          r_start[c] <= bus.data_in[TIME_W-1:0];
                end
            end
        end
    end

    // Prescaler, frame timer, status flags, gates and one-shot enable clearing
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_pcnt      <= '0;
            r_time      <= '0;
            r_intflag   <= 1'b0;
            r_frameflag <= 1'b0;
            r_gate      <= '0;
            r_ch_en     <= '0;
        end else begin
            if (w_rsttpu || w_tick) r_pcnt <= '0;
            else if (r_run)         r_pcnt <= r_pcnt + PRESC_W'(1);

            if (w_rsttpu)    r_time <= '0;
            else if (w_tick) r_time <= w_time_nxt;

            // A flag set outranks a simultaneous write-1-to-clear
            if (w_tick && !w_rsttpu && (w_time_nxt == r_int_time)) r_intflag <= 1'b1;
            else if (w_wr_status && bus.data_in[0])                  r_intflag <= 1'b0;
            if (w_tick && !w_rsttpu && (w_time_nxt == '0))           r_frameflag <= 1'b1;
            else if (w_wr_status && bus.data_in[1])                  r_frameflag <= 1'b0;

            r_gate <= w_rsttpu ? '0 : w_win;

            if (bus.we && (bus.addr == A_CH_EN)) r_ch_en <= bus.data_in[N_CH-1:0];
            else                                 r_ch_en <= r_ch_en & ~(r_oneshot & w_fall);
        end
    end

    assign bus.data_out = r_dout;
    assign bus.G_CLK_EN = r_gate;
    assign bus.TPUINT   = r_intflag & ~r_intmsk;
endmodule

// File: tb/tb_tpu_multislot.sv
// Directed bench for tpu_multislot: stimulus pushes expected outputs into a
// scoreboard queue, a monitor compares them one step after each clock edge.
module tb_tpu_multislot;
    localparam int N_CH = 4;

    typedef struct {
        int         kind;   // 0 data_out, 1 G_CLK_EN, 2 TPUINT
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic SYS_CLK = 1'b0;
    logic RST     = 1'b1;
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    tpu_multislot_if #(.N_CH(N_CH)) bus ();

    tpu_multislot #(.N_CH(N_CH), .TIME_W(7), .PRESC_W(16)) dut (
        .SYS_CLK (SYS_CLK),
        .RST     (RST),
        .bus     (bus)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    // Monitor: every item queued before an edge is checked just after it
    always @(posedge SYS_CLK) begin
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e = sb.pop_front();
            case (e.kind)
                0:       act = bus.data_out;
                1:       act = 8'(bus.G_CLK_EN);
                default: act = 8'(bus.TPUINT);
            endcase
            n_chk++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s @%0t: got 0x%02h, expected 0x%02h", e.name, $time, act, e.exp);
            end
        end
    end

    task automatic step(input logic [7:0] a, input logic [7:0] d, input logic w);
        @(negedge SYS_CLK);
        bus.addr    = a;
        bus.data_in = d;
        bus.we      = w;
    endtask

    task automatic expv(input int k, input logic [7:0] v, input string n);
        sb.push_back('{k, v, n});
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(a, d, 1'b1);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] v, input string n);
        step(a, 8'h00, 1'b0);
        expv(0, v, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr = 8'h00; bus.data_in = 8'h00; bus.we = 1'b0;

        // 1: reset and full register map read
        step(8'h00, 8'h00, 1'b0);
        step(8'h00, 8'h00, 1'b0);
        expv(0, 8'h00, "rst_dout"); expv(1, 8'h00, "rst_gate"); expv(2, 8'h00, "rst_int");
        RST = 1'b0;
        for (int a = 0; a < 8'h18; a++) rd(8'(a), 8'h00, "map_zero");
        wr(8'h09, 8'hFF);
        rd(8'h09, 8'h00, "unmapped_rd");

        // 2: PRESC=3 gives a tick every 4 cycles; wrap sets FRAMEFLAG (and INTFLAG, INT_TIME=0)
        wr(8'h02, 8'h03);
        wr(8'h00, 8'h04);
        for (int k = 1; k <= 515; k++) begin
            rd(8'h05, 8'(((k - 1) / 4) % 128), "time_presc3");
            if (k == 513) expv(2, 8'h01, "int_at_wrap");
        end
        rd(8'h01, 8'h03, "status_wrap");
        wr(8'h01, 8'h02);
        rd(8'h01, 8'h01, "frame_w1c");
        wr(8'h01, 8'h01);
        expv(2, 8'h00, "int_cleared");
        rd(8'h01, 8'h00, "status_clear");
        wr(8'h00, 8'h01);

        // 3: wrapping window on ch0, LEN=0 on ch1, PRESC=0
        wr(8'h02, 8'h00);
        wr(8'h10, 8'd126);
        wr(8'h11, 8'd4);
        wr(8'h12, 8'd0);
        wr(8'h06, 8'h03);
        wr(8'h00, 8'h04);
        for (int j = 1; j <= 135; j++) begin
            int t;
            t = (j - 1) % 128;
            rd(8'h05, 8'(t), "time_presc0");
            expv(1, (t == 126 || t == 127 || t == 0 || t == 1) ? 8'h01 : 8'h00, "wrap_window");
        end
        wr(8'h00, 8'h01);

        // 4: interrupt at TIME=10, masking, set beats same-cycle W1C
        wr(8'h04, 8'd10);
        wr(8'h01, 8'h03);
        wr(8'h00, 8'h04);
        for (int j = 1; j <= 12; j++) begin
            rd(8'h01, (j >= 11) ? 8'h01 : 8'h00, "intflag_rise");
            expv(2, (j >= 10) ? 8'h01 : 8'h00, "tpuint_rise");
        end
        wr(8'h00, 8'h06);
        expv(2, 8'h00, "int_masked");
        wr(8'h01, 8'h01);
        rd(8'h01, 8'h00, "intflag_w1c");
        wr(8'h00, 8'h03);
        wr(8'h01, 8'h03);
        wr(8'h00, 8'h06);
        for (int j = 1; j <= 9; j++) rd(8'h01, 8'h00, "pre_set");
        wr(8'h01, 8'h01);
        expv(2, 8'h00, "masked_at_set");
        rd(8'h01, 8'h01, "set_beats_w1c");
        wr(8'h00, 8'h04);
        expv(2, 8'h01, "unmask_int");
        rd(8'h01, 8'h01, "flag_kept");
        wr(8'h00, 8'h01);

        // 5: one-shot on ch2, START=5 LEN=2
        wr(8'h06, 8'h04);
        wr(8'h07, 8'h04);
        wr(8'h14, 8'd5);
        wr(8'h15, 8'd2);
        wr(8'h00, 8'h04);
        for (int j = 1; j <= 140; j++) begin
            rd(8'h06, (j <= 8) ? 8'h04 : 8'h00, "oneshot_en");
            expv(1, (j == 6 || j == 7) ? 8'h04 : 8'h00, "oneshot_gate");
        end
        wr(8'h00, 8'h01);

        // 6: RSTTPU at TIME=50 inside ch0 window, then RST mid-window
        wr(8'h07, 8'h00);
        wr(8'h06, 8'h01);
        wr(8'h10, 8'd40);
        wr(8'h11, 8'd20);
        wr(8'h00, 8'h04);
        for (int j = 1; j <= 50; j++) begin
            rd(8'h05, 8'(j - 1), "time_pre_rsttpu");
            expv(1, ((j - 1) >= 40 && (j - 1) < 60) ? 8'h01 : 8'h00, "gate_pre_rsttpu");
        end
        wr(8'h00, 8'h05);
        expv(1, 8'h00, "rsttpu_gate");
        rd(8'h05, 8'h00, "rsttpu_time");
        rd(8'h10, 8'd40, "kept_start");
        rd(8'h11, 8'd20, "kept_len");
        rd(8'h06, 8'h01, "kept_en");
        for (int j = 56; j <= 100; j++) begin
            rd(8'h08, ((j - 53) >= 40 && (j - 53) < 60) ? 8'h01 : 8'h00, "ch_active");
            expv(1, ((j - 52) >= 40 && (j - 52) < 60) ? 8'h01 : 8'h00, "gate_post_rsttpu");
        end
        step(8'h10, 8'h00, 1'b0);
        RST = 1'b1;
        expv(0, 8'h00, "rst_mid_dout"); expv(1, 8'h00, "rst_mid_gate"); expv(2, 8'h00, "rst_mid_int");
        step(8'h10, 8'h00, 1'b0);
        RST = 1'b0;
        rd(8'h10, 8'h00, "rst_cfg_clear");
        rd(8'h05, 8'h00, "rst_time_clear");

        @(negedge SYS_CLK);
        @(negedge SYS_CLK);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d items left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
